pixel_plot_sink: RTL and testbench

PIXEL_PLOT_SINK -- requirements
Module: pixel_plot_sink

---
 rtl/pixel_pkg.sv | 19 +
 rtl/pixel_fifo.sv | 56 +++++
 rtl/pixel_plot_sink.sv | 122 ++++++++++++
 tb/tb_pixel_plot_sink.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel-sink constants, the pixel word carried through the queue, and output FSM states.
package pixel_pkg;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int COL_W        = 3;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLOT = 1'b1
    } plot_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with a registered occupancy count.
// Latency: the head is visible the cycle after the push. Pushes while full and pops while empty are ignored.
// Backpressure: full is derived from the registered count only.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  pixel_t                   push_dat,
    input  logic                     pop,
    output pixel_t                   pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    pixel_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_dat   = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/pixel_plot_sink.sv
// Two-source pixel sink: arbitrate, clip/colour-key, queue, and strobe pixels into a framebuffer.
// Latency: accept at edge E -> fb_plot high after edge E+1. Ready is low when the queue is full; fb_busy stalls the pop.
// Optional PIXEL_SINK_STATS_EN adds drop_count and plot_count outputs.
module pixel_plot_sink
    import pixel_pkg::*;
#(
    parameter int             FIFO_DEPTH = 4,
    parameter int             SCREEN_W   = SCREEN_W_DEF,
    parameter int             SCREEN_H   = SCREEN_H_DEF,
    parameter logic [COL_W-1:0] KEY_COLOUR = 3'b000,
    parameter int             USE_KEY    = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             src0_valid,
    input  logic [X_W-1:0]   src0_x,
    input  logic [Y_W-1:0]   src0_y,
    input  logic [COL_W-1:0] src0_colour,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [X_W-1:0]   src1_x,
    input  logic [Y_W-1:0]   src1_y,
    input  logic [COL_W-1:0] src1_colour,
    output logic             src1_ready,
    output logic [X_W-1:0]   fb_x,
    output logic [Y_W-1:0]   fb_y,
    output logic [COL_W-1:0] fb_colour,
    output logic             fb_plot,
    input  logic             fb_busy,
`ifdef PIXEL_SINK_STATS_EN
    output logic [15:0]      drop_count,
    output logic [15:0]      plot_count,
`endif
    output logic             idle
);
    localparam logic [X_W:0] W_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] H_LIM = (Y_W+1)'(SCREEN_H);

    logic        r_run;
    logic        r_ptr;
    plot_state_t r_state;
    logic        r_plot;
    pixel_t      r_fb;
    logic        w_gnt0, w_gnt1, w_accept, w_drop, w_push, w_pop;
    logic        w_full, w_empty;
    pixel_t      w_sel, w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    // A lone valid source wins outright; the pointer only breaks ties.
    assign w_gnt0   = src0_valid && (!src1_valid || !r_ptr);
    assign w_gnt1   = src1_valid && (!src0_valid ||  r_ptr);
    assign src0_ready = r_run && !w_full && w_gnt0;
    assign src1_ready = r_run && !w_full && w_gnt1;
    assign w_accept = src0_ready || src1_ready;
    assign w_sel    = src1_ready ? pixel_t'{src1_x, src1_y, src1_colour}
                                 : pixel_t'{src0_x, src0_y, src0_colour};
    assign w_drop   = ({1'b0, w_sel.x} >= W_LIM) || ({1'b0, w_sel.y} >= H_LIM) ||
                      ((USE_KEY != 0) && (w_sel.colour == KEY_COLOUR));
    assign w_push   = w_accept && !w_drop;
    assign w_pop    = !w_empty && !fb_busy;

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (w_push),
        .push_dat (w_sel),
        .pop      (w_pop),
        .pop_dat  (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_run <= 1'b0;
            r_ptr <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept && src0_valid && src1_valid) r_ptr <= ~r_ptr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_plot  <= 1'b0;
            r_fb    <= '0;
        end else if (w_pop) begin
            r_state <= ST_PLOT;
            r_plot  <= 1'b1;
            r_fb    <= w_head;
        end else begin
            r_state <= ST_IDLE;
            r_plot  <= 1'b0;
        end
    end

    assign fb_plot   = r_plot;
    assign fb_x      = r_fb.x;
    assign fb_y      = r_fb.y;
    assign fb_colour = r_fb.colour;
    assign idle      = w_empty && (r_state == ST_IDLE);

`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_plot_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= '0;
            r_plot_cnt <= '0;
        end else begin
            if (w_accept && w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_pop) r_plot_cnt <= r_plot_cnt + 1'b1;
        end
    end

    assign drop_count = r_drop_cnt;
    assign plot_count = r_plot_cnt;
`endif
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: reset, latency, arbitration, clipping/keying, stall and mid-stream reset.
module tb_pixel_plot_sink;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       src0_valid = 1'b0, src1_valid = 1'b0;
    logic [7:0] src0_x = '0, src1_x = '0;
    logic [6:0] src0_y = '0, src1_y = '0;
    logic [2:0] src0_colour = '0, src1_colour = '0;
    logic       src0_ready, src1_ready;
    logic [7:0] fb_x;
    logic [6:0] fb_y;
    logic [2:0] fb_colour;
    logic       fb_plot;
    logic       fb_busy = 1'b0;
    logic       idle;
`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] drop_count, plot_count;
`endif

    pixel_plot_sink dut (
        .clk(clk), .resetn(resetn),
        .src0_valid(src0_valid), .src0_x(src0_x), .src0_y(src0_y), .src0_colour(src0_colour), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_x(src1_x), .src1_y(src1_y), .src1_colour(src1_colour), .src1_ready(src1_ready),
        .fb_x(fb_x), .fb_y(fb_y), .fb_colour(fb_colour), .fb_plot(fb_plot), .fb_busy(fb_busy),
`ifdef PIXEL_SINK_STATS_EN
        .drop_count(drop_count), .plot_count(plot_count),
`endif
        .idle(idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_px[$], q_py[$], q_pc[$], q_pcyc[$];
    int q_acc[$], q_acyc[$];

    always @(posedge clk) cyc++;

    // Inputs are stable at the falling edge, so valid&ready here means the next rising edge accepts.
    always @(negedge clk) begin
        if (fb_plot) begin
            q_px.push_back(int'(fb_x));
            q_py.push_back(int'(fb_y));
            q_pc.push_back(int'(fb_colour));
            q_pcyc.push_back(cyc);
        end
        if (src0_valid && src0_ready) begin q_acc.push_back(0); q_acyc.push_back(cyc + 1); end
        if (src1_valid && src1_ready) begin q_acc.push_back(1); q_acyc.push_back(cyc + 1); end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        q_px.delete(); q_py.delete(); q_pc.delete(); q_pcyc.delete();
        q_acc.delete(); q_acyc.delete();
    endtask

    task automatic send0(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                         input int max_cyc, output bit ok);
        src0_valid = 1'b1; src0_x = x; src0_y = y; src0_colour = c;
        ok = 1'b0;
        for (int n = 0; n < max_cyc && !ok; n++) begin
            @(negedge clk);
            if (src0_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        src0_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int i0, i1, guard, nacc;

        // Reset state, with a source already requesting
        src0_valid = 1'b1; src0_colour = 3'd1;
        #12;
        chk("rst_plot", int'(fb_plot), 0);
        chk("rst_idle", int'(idle), 1);
        chk("rst_ready0", int'(src0_ready), 0);
        chk("rst_fbx", int'(fb_x), 0);
        src0_valid = 1'b0;
        @(negedge clk); resetn = 1'b1;
        wait_cyc(2);
        clear_logs();

        // Single pixel latency and data
        send0(8'd10, 7'd20, 3'b101, 10, ok);
        chk("single_accept", int'(ok), 1);
        wait_cyc(5);
        chk("single_nplots", q_px.size(), 1);
        if (q_px.size() == 1) begin
            chk("single_x", q_px[0], 10);
            chk("single_y", q_py[0], 20);
            chk("single_c", q_pc[0], 5);
            chk("single_lat", q_pcyc[0] - q_acyc[0], 1);
        end
        chk("single_idle", int'(idle), 1);
        clear_logs();

        // Both sources valid: grants alternate starting from src0
        i0 = 0; i1 = 0; guard = 0;
        while ((i0 < 4 || i1 < 4) && guard < 60) begin
            src0_valid = (i0 < 4); src0_x = 8'(i0);       src0_y = 7'd1; src0_colour = 3'd1;
            src1_valid = (i1 < 4); src1_x = 8'(100 + i1); src1_y = 7'd2; src1_colour = 3'd2;
            @(negedge clk);
            if (src0_valid && src0_ready) i0++;
            if (src1_valid && src1_ready) i1++;
            @(posedge clk); #1;
            guard++;
        end
        src0_valid = 1'b0; src1_valid = 1'b0;
        chk("arb_done", i0 + i1, 8);
        wait_cyc(6);
        chk("arb_nacc", q_acc.size(), 8);
        chk("arb_nplots", q_px.size(), 8);
        for (int k = 0; k < 8 && k < q_acc.size(); k++) chk("arb_src", q_acc[k], k % 2);
        for (int k = 0; k < 8 && k < q_px.size(); k++)
            chk("arb_order_x", q_px[k], (k % 2 == 0) ? k / 2 : 100 + k / 2);
        clear_logs();

        // Clipped and keyed pixels are consumed but never plotted; the corner pixel is kept
        send0(8'd160, 7'd5, 3'd1, 10, ok);   chk("clip_x_acc", int'(ok), 1);
        send0(8'd5, 7'd120, 3'd1, 10, ok);   chk("clip_y_acc", int'(ok), 1);
        send0(8'd3, 7'd3, 3'd0, 10, ok);     chk("key_acc", int'(ok), 1);
        wait_cyc(5);
        chk("drop_nplots", q_px.size(), 0);
        chk("drop_idle", int'(idle), 1);
`ifdef PIXEL_SINK_STATS_EN
        chk("drop_count", int'(drop_count), 3);
`endif
        send0(8'd159, 7'd119, 3'd7, 10, ok);
        wait_cyc(4);
        chk("corner_nplots", q_px.size(), 1);
        if (q_px.size() == 1) begin
            chk("corner_x", q_px[0], 159);
            chk("corner_y", q_py[0], 119);
        end
        clear_logs();

        // Stall: only FIFO_DEPTH pixels fit, outputs hold
        fb_busy = 1'b1;
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            send0(8'(20 + k), 7'(k), 3'd1, 6, ok);
            if (ok) nacc++;
        end
        chk("stall_nacc", nacc, 4);
        src0_valid = 1'b1; src0_x = 8'd24; src0_y = 7'd4; src0_colour = 3'd1;
        @(negedge clk);
        chk("stall_ready", int'(src0_ready), 0);
        chk("stall_plot", int'(fb_plot), 0);
        chk("stall_hold_x", int'(fb_x), 159);
        @(posedge clk); #1;
        src0_valid = 1'b0;
        fb_busy = 1'b0;
        send0(8'd24, 7'd4, 3'd1, 10, ok);  chk("stall_acc5", int'(ok), 1);
        send0(8'd25, 7'd5, 3'd1, 10, ok);  chk("stall_acc6", int'(ok), 1);
        wait_cyc(8);
        chk("stall_nplots", q_px.size(), 6);
        for (int k = 0; k < 6 && k < q_px.size(); k++) chk("stall_order", q_px[k], 20 + k);
        for (int k = 1; k < 4 && k < q_pcyc.size(); k++) chk("stall_b2b", q_pcyc[k] - q_pcyc[0], k);
        clear_logs();

        // Reset mid-stream with pixels queued and a plot in flight
        fb_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send0(8'(40 + k), 7'd9, 3'd3, 6, ok);
            chk("mid_fill", int'(ok), 1);
        end
        fb_busy = 1'b0;
        @(posedge clk); #2;
        chk("mid_plot_pre", int'(fb_plot), 1);
        resetn = 1'b0;
        #1;
        chk("mid_plot_rst", int'(fb_plot), 0);
        chk("mid_idle_rst", int'(idle), 1);
        chk("mid_fbx_rst", int'(fb_x), 0);
        @(negedge clk); resetn = 1'b1;
        clear_logs();
        wait_cyc(8);
        chk("mid_nplots", q_px.size(), 0);
        chk("mid_idle", int'(idle), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
